// File: rtl/set_assoc_cache.sv
// Purpose: N-way (1 or 2) set-associative, write-through / write-allocate cache with LRU and block fill.
// Latency: hits are combinational (same cycle); a miss costs a WORDS-word fill plus one UPDATE cycle.
// Backpressure: fsm_busy stalls the requester from the miss cycle through UPDATE; memory is paced by mem_data_valid.
//
// Ports: clk/rst (async active-low); req_* processor request; rsp_rdata/hit lookup result;
//        fsm_busy stall; mem_* memory side (fill reads, write-through writes, returned fill data);
//        hit_cnt/miss_cnt saturating statistics.
module set_assoc_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int WORDS  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wrt,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              hit,
    output logic              fsm_busy,
    output logic              mem_read_req,
    output logic              mem_wrt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_UPDATE} state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WAY_W-1:0]   vic_q, vic_d;
    logic [OFF_W:0]     iss_q, iss_d;     // fill requests issued; MSB set = all issued
    logic [OFF_W:0]     rcv_q, rcv_d;     // fill words received
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];
    logic [SETS-1:0]    lru_q, lru_d;     // per set: way to evict next

    // Storage arrays carry no reset; valid bits alone decide visibility.
    logic [DATA_W-1:0]  data_ram [WAYS][SETS*WORDS];
    logic [TAG_W-1:0]   tag_ram  [WAYS][SETS];

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req_act;
    logic               hit_int;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   vic;
    logic               miss;
    logic               fill_we;

    assign req_off = req_addr[OFF_W:1];
    assign req_idx = req_addr[OFF_W+IDX_W:OFF_W+1];
    assign req_tag = req_addr[ADDR_W-1:ADDR_W-TAG_W];

    // Requests only count in IDLE and never while reset is asserted, so all
    // outputs read zero during reset even if the requester keeps req_valid high.
    assign req_act = req_valid & rst & (state_q == S_IDLE);

    always_comb begin
        hit_int = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_ram[w][req_idx] == req_tag)) begin
                hit_int = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Lowest-numbered invalid way wins; with both valid fall back to LRU.
        vic = (WAYS > 1) ? WAY_W'(lru_q[req_idx]) : '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                vic = WAY_W'(w);
            end
        end
    end

    assign hit     = req_act & hit_int;
    assign miss    = req_act & ~hit_int;
    assign fill_we = (state_q == S_FILL) & mem_data_valid & ~rcv_q[OFF_W];

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        vic_d      = vic_q;
        iss_d      = iss_q;
        rcv_d      = rcv_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        lru_d      = lru_q;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
                    if (WAYS == 2) begin
                        lru_d[req_idx] = ~hit_way[0];
                    end
                end
                if (miss) begin
                    miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
                    tag_d      = req_tag;
                    idx_d      = req_idx;
                    vic_d      = vic;
                    iss_d      = '0;
                    rcv_d      = '0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (!iss_q[OFF_W]) begin
                    iss_d = iss_q + 1'b1;
                end
                if (fill_we) begin
                    rcv_d = rcv_q + 1'b1;
                    if (rcv_q == (OFF_W+1)'(WORDS - 1)) begin
                        state_d = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                valid_d[idx_q][vic_q] = 1'b1;
                if (WAYS == 2) begin
                    lru_d[idx_q] = ~vic_q[0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            vic_q      <= '0;
            iss_q      <= '0;
            rcv_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            lru_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            vic_q      <= vic_d;
            iss_q      <= iss_d;
            rcv_q      <= rcv_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            lru_q      <= lru_d;
            valid_q    <= valid_d;
        end
    end

    // Fill writes and write hits are mutually exclusive (FILL vs IDLE).
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_ram[vic_q][{idx_q, rcv_q[OFF_W-1:0]}] <= mem_rdata;
        end else if (mem_wrt) begin
            data_ram[hit_way][{req_idx, req_off}] <= req_wdata;
        end
        if (state_q == S_UPDATE) begin
            tag_ram[vic_q][idx_q] <= tag_q;
        end
    end

    assign rsp_rdata    = hit ? data_ram[hit_way][{req_idx, req_off}] : '0;
    assign mem_read_req = (state_q == S_FILL) & ~iss_q[OFF_W];
    assign mem_wrt      = hit & req_wrt;
    assign mem_wdata    = mem_wrt ? req_wdata : '0;
    assign mem_addr     = mem_wrt      ? req_addr :
                          mem_read_req ? {tag_q, idx_q, iss_q[OFF_W-1:0], 1'b0} : '0;
    assign fsm_busy     = (state_q != S_IDLE) | miss;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
module tb_set_assoc_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wrt = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] rsp_rdata;
    logic        hit;
    logic        fsm_busy;
    logic        mem_read_req;
    logic        mem_wrt;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    set_assoc_cache dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wrt(req_wrt),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_rdata(rsp_rdata),
        .hit(hit), .fsm_busy(fsm_busy), .mem_read_req(mem_read_req),
        .mem_wrt(mem_wrt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bad(string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {bit wrt; logic [15:0] addr; logic [15:0] data;} rsp_t;
    rsp_t        rsp_q[$];
    logic [15:0] fill_q[$];
    logic [15:0] ref_mem[int];
    logic [15:0] env_mem[int];
    int unsigned lru_l[64][$];   // resident tags per set, least recent first
    int          hit_exp = 0;
    int          miss_exp = 0;

    function automatic logic [15:0] base_word(logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h6B1D;
    endfunction

    function automatic int wkey(logic [15:0] a);
        return int'({a[15:1], 1'b0});
    endfunction

    function automatic logic [15:0] ref_rd(logic [15:0] a);
        return ref_mem.exists(wkey(a)) ? ref_mem[wkey(a)] : base_word({a[15:1], 1'b0});
    endfunction

    function automatic logic [15:0] env_rd(logic [15:0] a);
        return env_mem.exists(wkey(a)) ? env_mem[wkey(a)] : base_word({a[15:1], 1'b0});
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++) lru_l[s].delete();
        hit_exp  = 0;
        miss_exp = 0;
    endtask

    // ---------------- memory responder ----------------
    typedef struct {logic [15:0] addr; int due;} pend_t;
    pend_t pend[$];
    int    cyc = 0;
    int    sent = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_read_req) begin
                pend_t p;
                p.addr = mem_addr;
                p.due  = cyc + 1 + int'($urandom_range(0, 2));
                pend.push_back(p);
            end
            if (mem_wrt) env_mem[wkey(mem_addr)] = mem_wdata;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                pend.delete();
                mem_data_valid = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_data_valid = 1'b1;
                mem_rdata      = env_rd(pend[0].addr);
                void'(pend.pop_front());
                sent++;
            end else begin
                mem_data_valid = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (hit) begin
            if (rsp_q.size() == 0) begin
                bad("unexpected_hit");
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("mem_wrt_on_hit", mem_wrt, e.wrt);
                if (e.wrt) begin
                    chk("wt_addr", mem_addr, e.addr);
                    chk("wt_data", mem_wdata, e.data);
                end else begin
                    chk("rdata", rsp_rdata, e.data);
                end
            end
        end else if (mem_wrt) begin
            bad("stray_mem_wrt");
        end
        if (mem_read_req) begin
            if (fill_q.size() == 0) bad("unexpected_mem_read_req");
            else chk("fill_addr", mem_addr, fill_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(bit wrt, logic [15:0] addr, logic [15:0] wdata);
        int unsigned tag;
        int unsigned idx;
        bit          hp;
        int          pos;
        int          n;
        rsp_t        e;
        tag = int'(addr[15:10]);
        idx = int'(addr[9:4]);
        hp  = 1'b0;
        pos = 0;
        foreach (lru_l[idx][i]) if (lru_l[idx][i] == tag) begin hp = 1'b1; pos = i; end
        if (hp) begin
            lru_l[idx].delete(pos);
        end else begin
            miss_exp++;
            for (int k = 0; k < 8; k++) fill_q.push_back({addr[15:4], 3'(k), 1'b0});
            if (lru_l[idx].size() == 2) void'(lru_l[idx].pop_front());
        end
        lru_l[idx].push_back(tag);
        hit_exp++;
        e.wrt  = wrt;
        e.addr = addr;
        e.data = wrt ? wdata : ref_rd(addr);
        rsp_q.push_back(e);
        if (wrt) ref_mem[wkey(addr)] = wdata;

        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_wrt   = wrt;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        chk("first_cycle_hit", hit, hp);
        chk("first_cycle_busy", fsm_busy, !hp);
        n = 0;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!hit) bad("timeout_waiting_for_hit");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", fsm_busy, 0);
        chk("hit_cnt", hit_cnt, hit_exp);
        chk("miss_cnt", miss_cnt, miss_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        // Reset: outputs must be zero even with a request pending.
        req_valid = 1'b1;
        req_addr  = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hit", hit, 0);
        chk("rst_busy", fsm_busy, 0);
        chk("rst_rd_req", mem_read_req, 0);
        chk("rst_mem_wrt", mem_wrt, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed sequence.
        do_req(0, 16'h1234, 16'h0);
        do_req(0, 16'h1234, 16'h0);
        do_req(0, 16'h5634, 16'h0);
        do_req(0, 16'h1234, 16'h0);
        do_req(0, 16'h9A34, 16'h0);
        do_req(0, 16'h1234, 16'h0);
        do_req(0, 16'h5634, 16'h0);
        chk("miss_cnt_conflict", miss_cnt, 4);
        do_req(1, 16'h1234, 16'hBEEF);
        do_req(0, 16'h1234, 16'h0);
        do_req(1, 16'h2002, 16'hCAFE);
        do_req(0, 16'h2002, 16'h0);

        // Reset in the middle of a fill of 0x4000.
        for (int k = 0; k < 8; k++) fill_q.push_back({12'h400, 3'(k), 1'b0});
        s0 = sent;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_wrt   = 1'b0;
        req_addr  = 16'h4000;
        n = 0;
        while (sent < s0 + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sent < s0 + 3) bad("timeout_waiting_fill_words");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy", fsm_busy, 0);
        chk("midrst_rd_req", mem_read_req, 0);
        chk("midrst_hit_cnt", hit_cnt, 0);
        chk("midrst_miss_cnt", miss_cnt, 0);
        req_valid = 1'b0;
        fill_q.delete();
        model_reset();
        @(negedge clk);
        chk("midrst_rd_req_later", mem_read_req, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_req(0, 16'h4000, 16'h0);
        do_req(0, 16'h4006, 16'h0);

        // Randomized traffic over a few sets and tags to force conflicts.
        for (int i = 0; i < 250; i++) begin
            logic [15:0] a;
            a = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 3'($urandom), 1'($urandom)};
            do_req($urandom_range(0, 3) == 0, a, 16'($urandom));
        end

        repeat (5) @(posedge clk);
        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("fill_q_drained", fill_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
